// File: rtl/clk_rst_seq_if.sv
// ---------------------------------------------------------------------------
// clk_rst_seq_if
// Bundles the status/control signals of the clock-subsystem reset sequencer.
//   pll_locked_i   PLL lock, synchronized to the CSR clock
//   clk_ok_i       per-domain clock-alive flags, synchronized to the CSR clock
//   sw_rst_req_i   single-cycle software request to re-run the sequence
//   fault_clr_i    single-cycle clear of the sticky fault flags
//   dom_rst_o      per-domain active-high resets
//   seq_done_o     all domains released
//   state_o        sequencer state code
//   fault_o        sticky lock/clock-loss flag
//   fault_dom_o    sticky record of clk_ok_i bits low at fault entry
//   restart_cnt_o  saturating count of fault entries
// The slave modport is the sequencer side; master is the CSR/stimulus side.
// ---------------------------------------------------------------------------
interface clk_rst_seq_if #(
  parameter int NUM_DOM = 5
);
  logic               pll_locked_i;
  logic [NUM_DOM-1:0] clk_ok_i;
  logic               sw_rst_req_i;
  logic               fault_clr_i;
  logic [NUM_DOM-1:0] dom_rst_o;
  logic               seq_done_o;
  logic [2:0]         state_o;
  logic               fault_o;
  logic [NUM_DOM-1:0] fault_dom_o;
  logic [7:0]         restart_cnt_o;

  modport master (
    output pll_locked_i, clk_ok_i, sw_rst_req_i, fault_clr_i,
    input  dom_rst_o, seq_done_o, state_o, fault_o, fault_dom_o, restart_cnt_o
  );

  modport slave (
    input  pll_locked_i, clk_ok_i, sw_rst_req_i, fault_clr_i,
    output dom_rst_o, seq_done_o, state_o, fault_o, fault_dom_o, restart_cnt_o
  );
endinterface

// File: rtl/clk_rst_seq.sv
// ---------------------------------------------------------------------------
// clk_rst_seq
// Reset sequencer for the clock subsystem, clocked by the CSR clock.
// Waits for the PLL lock and all clock-alive flags to be stable, then releases
// the per-domain resets one by one in index order with a fixed gap. Any loss of
// lock/clock after the wait phase re-asserts every domain reset and records a
// sticky fault; a software request re-runs the sequence without a fault.
// Ports:
//   clk_csr   CSR clock, the only clock of this block
//   rst_csr   asynchronous active-high reset
//   bus       clk_rst_seq_if slave modport (status inputs, reset/CSR outputs)
// ---------------------------------------------------------------------------
module clk_rst_seq #(
  parameter int NUM_DOM         = 5,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int STEP_DLY_CYC    = 256,
  parameter int CNT_W           = 16
) (
  input  logic         clk_csr,
  input  logic         rst_csr,
  clk_rst_seq_if.slave bus
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DLY_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_DOM-1:0] dom_rst_q;
  logic               seq_done_q;
  logic               fault_q;
  logic [NUM_DOM-1:0] fault_dom_q;
  logic [7:0]         restart_cnt_q;
  logic               good;

  // Everything the sequencer watches collapses into one health flag.
  assign good = bus.pll_locked_i & (&bus.clk_ok_i);

  // Single-process sequencer. cnt_q is shared: it is the stability counter in
  // WAIT_LOCK and the inter-release step counter in RELEASE. The fault_clr_i
  // assignment comes first so that a fault entry on the same edge overrides it.
  always_ff @(posedge clk_csr or posedge rst_csr) begin
    if (rst_csr) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      dom_rst_q     <= '1;
      seq_done_q    <= 1'b0;
      fault_q       <= 1'b0;
      fault_dom_q   <= '0;
      restart_cnt_q <= '0;
    end else begin
      if (bus.fault_clr_i) begin
        fault_q     <= 1'b0;
        fault_dom_q <= '0;
      end
      case (state_q)
        IDLE: begin
          state_q <= WAIT_LOCK;
          cnt_q   <= '0;
        end
        WAIT_LOCK: begin
          dom_rst_q  <= '1;
          seq_done_q <= 1'b0;
          if (bus.sw_rst_req_i || !good) begin
            cnt_q <= '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RELEASE, RUN: begin
          // Loss of health beats a simultaneous software request.
          if (!good) begin
            state_q     <= FAULT;
            cnt_q       <= '0;
            dom_rst_q   <= '1;
            seq_done_q  <= 1'b0;
            fault_q     <= 1'b1;
            fault_dom_q <= fault_dom_q | ~bus.clk_ok_i;
            if (restart_cnt_q != 8'hFF) begin
              restart_cnt_q <= restart_cnt_q + 8'd1;
            end
          end else if (bus.sw_rst_req_i) begin
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            dom_rst_q  <= '1;
            seq_done_q <= 1'b0;
          end else if (state_q == RELEASE) begin
            if (cnt_q == STEP_LAST) begin
              dom_rst_q[idx_q] <= 1'b0;
              cnt_q            <= '0;
              if (idx_q == IDX_LAST) begin
                state_q    <= RUN;
                seq_done_q <= 1'b1;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        FAULT: begin
          state_q <= WAIT_LOCK;
          cnt_q   <= '0;
        end
        default: begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          dom_rst_q  <= '1;
          seq_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dom_rst_o     = dom_rst_q;
  assign bus.seq_done_o    = seq_done_q;
  assign bus.state_o       = state_q;
  assign bus.fault_o       = fault_q;
  assign bus.fault_dom_o   = fault_dom_q;
  assign bus.restart_cnt_o = restart_cnt_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_clk_rst_seq
// Directed bench for clk_rst_seq with LOCK_STABLE_CYC=16 and STEP_DLY_CYC=4.
// Each vector holds the inputs for a run of clock edges plus the outputs
// expected after the last of those edges.
// ---------------------------------------------------------------------------
module tb_clk_rst_seq;

  typedef struct {
    int         ncyc;
    logic       pll;
    logic [4:0] ok;
    logic       sw;
    logic       clr;
    logic [4:0] expDom;
    logic       expDone;
    logic [2:0] expState;
    logic       expFault;
    logic [4:0] expFdom;
    logic [7:0] expRcnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  clk_rst_seq_if #(.NUM_DOM(5)) bus ();

  clk_rst_seq #(
    .NUM_DOM(5),
    .LOCK_STABLE_CYC(16),
    .STEP_DLY_CYC(4),
    .CNT_W(16)
  ) dut (
    .clk_csr(clk),
    .rst_csr(rst),
    .bus(bus.slave)
  );

  // Free-running clock: rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkField(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkField({tag, " dom_rst"},  8'(bus.dom_rst_o),     8'(v.expDom));
    checkField({tag, " seq_done"}, 8'(bus.seq_done_o),    8'(v.expDone));
    checkField({tag, " state"},    8'(bus.state_o),       8'(v.expState));
    checkField({tag, " fault"},    8'(bus.fault_o),       8'(v.expFault));
    checkField({tag, " fault_dom"},8'(bus.fault_dom_o),   8'(v.expFdom));
    checkField({tag, " restarts"}, bus.restart_cnt_o,     v.expRcnt);
  endtask

  // Drives the inputs, lets ncyc edges pass (request pulses last one edge),
  // samples 1 time unit after the final edge.
  task automatic applyStimulus(input vec_t v);
    bus.pll_locked_i = v.pll;
    bus.clk_ok_i     = v.ok;
    bus.sw_rst_req_i = v.sw;
    bus.fault_clr_i  = v.clr;
    for (int k = 0; k < v.ncyc; k++) begin
      @(posedge clk);
      #1;
      bus.sw_rst_req_i = 1'b0;
      bus.fault_clr_i  = 1'b0;
    end
  endtask

  task automatic runVec(input string tag, input vec_t v);
    applyStimulus(v);
    checkOutput(tag, v);
  endtask

  // Asserts reset across a falling edge, checks reset values, and releases
  // it so that the next rising edge is edge 1.
  task automatic resetDut();
    vec_t r;
    r = '{0, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd0, 1'b0, 5'h00, 8'd0};
    @(negedge clk);
    rst = 1'b1;
    bus.pll_locked_i = 1'b1;
    bus.clk_ok_i     = 5'h1F;
    bus.sw_rst_req_i = 1'b0;
    bus.fault_clr_i  = 1'b0;
    #1;
    checkOutput("reset", r);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl [23];
  vec_t v;

  initial begin
    // Main sequence, loss of one clock in RUN, fault clear, software reset,
    // and simultaneous loss+software request. Edge numbers in comments.
    tbl[0]  = '{1,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd1, 1'b0, 5'h00, 8'd0}; // 1
    tbl[1]  = '{15, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd1, 1'b0, 5'h00, 8'd0}; // 16
    tbl[2]  = '{1,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd2, 1'b0, 5'h00, 8'd0}; // 17
    tbl[3]  = '{3,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd2, 1'b0, 5'h00, 8'd0}; // 20
    tbl[4]  = '{1,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h1E, 1'b0, 3'd2, 1'b0, 5'h00, 8'd0}; // 21
    tbl[5]  = '{4,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h1C, 1'b0, 3'd2, 1'b0, 5'h00, 8'd0}; // 25
    tbl[6]  = '{4,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h18, 1'b0, 3'd2, 1'b0, 5'h00, 8'd0}; // 29
    tbl[7]  = '{4,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h10, 1'b0, 3'd2, 1'b0, 5'h00, 8'd0}; // 33
    tbl[8]  = '{3,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h10, 1'b0, 3'd2, 1'b0, 5'h00, 8'd0}; // 36
    tbl[9]  = '{1,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h00, 1'b1, 3'd3, 1'b0, 5'h00, 8'd0}; // 37
    tbl[10] = '{3,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h00, 1'b1, 3'd3, 1'b0, 5'h00, 8'd0}; // 40
    tbl[11] = '{1,  1'b1, 5'h1B, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd4, 1'b1, 5'h04, 8'd1}; // 41
    tbl[12] = '{1,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd1, 1'b1, 5'h04, 8'd1}; // 42
    tbl[13] = '{1,  1'b1, 5'h1F, 1'b0, 1'b1, 5'h1F, 1'b0, 3'd1, 1'b0, 5'h00, 8'd1}; // 43
    tbl[14] = '{14, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd1, 1'b0, 5'h00, 8'd1}; // 57
    tbl[15] = '{1,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd2, 1'b0, 5'h00, 8'd1}; // 58
    tbl[16] = '{4,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h1E, 1'b0, 3'd2, 1'b0, 5'h00, 8'd1}; // 62
    tbl[17] = '{16, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h00, 1'b1, 3'd3, 1'b0, 5'h00, 8'd1}; // 78
    tbl[18] = '{1,  1'b1, 5'h1F, 1'b1, 1'b0, 5'h1F, 1'b0, 3'd1, 1'b0, 5'h00, 8'd1}; // 79
    tbl[19] = '{35, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h10, 1'b0, 3'd2, 1'b0, 5'h00, 8'd1}; // 114
    tbl[20] = '{1,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h00, 1'b1, 3'd3, 1'b0, 5'h00, 8'd1}; // 115
    tbl[21] = '{1,  1'b0, 5'h1F, 1'b1, 1'b0, 5'h1F, 1'b0, 3'd4, 1'b1, 5'h00, 8'd2}; // 116
    tbl[22] = '{1,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd1, 1'b1, 5'h00, 8'd2}; // 117

    bus.pll_locked_i = 1'b1;
    bus.clk_ok_i     = 5'h1F;
    bus.sw_rst_req_i = 1'b0;
    bus.fault_clr_i  = 1'b0;

    resetDut();
    for (int i = 0; i < 23; i++) begin
      runVec($sformatf("tbl%0d", i), tbl[i]);
    end

    // One-cycle glitch on clk_ok_i[2], sampled at edge 11, restarts the
    // stability count so the first release moves from edge 21 to edge 31.
    resetDut();
    runVec("glitch e10", '{10, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd1, 1'b0, 5'h00, 8'd0});
    runVec("glitch e11", '{1,  1'b1, 5'h1B, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd1, 1'b0, 5'h00, 8'd0});
    runVec("glitch e26", '{15, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd1, 1'b0, 5'h00, 8'd0});
    runVec("glitch e27", '{1,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd2, 1'b0, 5'h00, 8'd0});
    runVec("glitch e30", '{3,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd2, 1'b0, 5'h00, 8'd0});
    runVec("glitch e31", '{1,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h1E, 1'b0, 3'd2, 1'b0, 5'h00, 8'd0});

    // Lock loss mid-RELEASE after domain 1 is out of reset, then a full re-run.
    resetDut();
    runVec("rel e25",    '{25, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h1C, 1'b0, 3'd2, 1'b0, 5'h00, 8'd0});
    runVec("rel loss",   '{1,  1'b0, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd4, 1'b1, 5'h00, 8'd1});
    runVec("rel wait",   '{1,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd1, 1'b1, 5'h00, 8'd1});
    runVec("rel rerun4", '{35, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h10, 1'b0, 3'd2, 1'b1, 5'h00, 8'd1});
    runVec("rel rerun5", '{1,  1'b1, 5'h1F, 1'b0, 1'b0, 5'h00, 1'b1, 3'd3, 1'b1, 5'h00, 8'd1});

    // 256 forced lock losses from RELEASE: restart count saturates at 255.
    resetDut();
    v = '{17, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd2, 1'b0, 5'h00, 8'd0};
    runVec("sat start", v);
    for (int n = 1; n <= 256; n++) begin
      v = '{1, 1'b0, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd4, 1'b1, 5'h00, 8'd0};
      v.expRcnt = (n > 255) ? 8'd255 : 8'(n);
      applyStimulus(v);
      if (n == 1 || n == 255 || n == 256) begin
        checkOutput($sformatf("sat %0d", n), v);
      end
      applyStimulus('{17, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd2, 1'b1, 5'h00, 8'd255});
    end
    checkOutput("sat release", '{0, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd2, 1'b1, 5'h00, 8'd255});

    // Clear coinciding with a clock loss is lost; a later clear works.
    runVec("clr+loss", '{1, 1'b1, 5'h0F, 1'b0, 1'b1, 5'h1F, 1'b0, 3'd4, 1'b1, 5'h10, 8'd255});
    runVec("clr only", '{1, 1'b1, 5'h1F, 1'b0, 1'b1, 5'h1F, 1'b0, 3'd1, 1'b0, 5'h00, 8'd255});

    // Asynchronous reset between edges while domain 0 is released.
    runVec("pre arst", '{20, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h1E, 1'b0, 3'd2, 1'b0, 5'h00, 8'd255});
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst", '{0, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd0, 1'b0, 5'h00, 8'd0});
    @(negedge clk);
    rst = 1'b0;
    runVec("post arst", '{1, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h1F, 1'b0, 3'd1, 1'b0, 5'h00, 8'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
